// File: rtl/apb_bist_pkg.sv
// apb_bist_pkg: shared types and helpers for the APB BIST master.
//   bist_mode_e  - traffic class selected per run
//   bist_state_e - bus sequencer state encodings
//   LfsrTaps     - Galois feedback mask, polynomial x^32 + x^22 + x^2 + x + 1
//   sat_inc16()  - 16-bit saturating increment used by the status counters
package apb_bist_pkg;

  typedef enum logic [2:0] {
    ModeSeq    = 3'd0,
    ModeRand   = 3'd1,
    ModeStrobe = 3'd2,
    ModeB2b    = 3'd3,
    ModeAor    = 3'd4
  } bist_mode_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StAccess = 3'd2,
    StNext   = 3'd3,
    StFinish = 3'd4
  } bist_state_e;

  // Right-shifting Galois form: bits 31, 21, 1, 0 are taps 32, 22, 2, 1.
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/apb_bist_lfsr.sv
// apb_bist_lfsr: 32-bit Galois LFSR for the RAND traffic class.
//   clk_i, rst_i  clock, asynchronous active-high reset (value returns to 1)
//   load_i        load seed_i (zero seed is replaced by 1 so the LFSR never locks up)
//   advance_i     step once
//   value_o       current state
//   next_o        state after one step, available combinationally
module apb_bist_lfsr
  import apb_bist_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        advance_i,
  output logic [31:0] value_o,
  output logic [31:0] next_o
);

  logic [31:0] value_q, value_d;

  always_comb begin
    next_o = {1'b0, value_q[31:1]};
    if (value_q[0]) begin
      next_o = next_o ^ LfsrTaps;
    end
  end

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = (seed_i == 32'd0) ? 32'd1 : seed_i;
    end else if (advance_i) begin
      value_d = next_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= 32'd1;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/apb_bist_master.sv
// apb_bist_master: synthesizable self-checking APB master. Generates SEQ, RAND, STROBE,
// B2B and AOR traffic against an APB slave window and checks read-back data.
//   PCLK, PRESET          clock, asynchronous active-high reset
//   start, mode,          run request (pulse), traffic class, transfer count for RAND/AOR,
//   num_xfers, seed       data/LFSR seed
//   PSEL..PSTRB           APB requester outputs; PRDATA, PREADY, PSLVERR responder inputs
//   busy, done, pass      run status; pass is valid from done and held until next start
//   err_count,            saturating data-miscompare and PSLVERR counters
//   slverr_count
//   timeout               sticky abort flag after MAX_WAIT stalled ACCESS cycles
// Optional: define APB_BIST_ERRLOG_EN to add fail_valid/fail_addr/fail_exp/fail_act, which
// capture the first miscompare of a run.
module apb_bist_master
  import apb_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       NUM_WORDS = 256,
  parameter int unsigned       MAX_WAIT  = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [15:0]         num_xfers,
  input  logic [DATA_W-1:0]   seed,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [15:0]         slverr_count,
  output logic                timeout
`ifdef APB_BIST_ERRLOG_EN
  ,
  output logic                fail_valid,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_exp,
  output logic [DATA_W-1:0]   fail_act
`endif
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned WaitW    = $clog2(MAX_WAIT + 1);
  localparam int unsigned SeedW    = (DATA_W < 32) ? DATA_W : 32;
  localparam logic [15:0] WordLast = 16'(NUM_WORDS - 1);

  localparam logic [2:0] StateIdle   = StIdle;
  localparam logic [2:0] StateSetup  = StSetup;
  localparam logic [2:0] StateAccess = StAccess;
  localparam logic [2:0] StateNext   = StNext;
  localparam logic [2:0] StateFinish = StFinish;

  logic [2:0]        state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [15:0]       num_q, num_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        phase_q, phase_d;
  logic [15:0]       rand_idx_q, rand_idx_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              last_q, last_d;
  logic [15:0]       err_q, err_d;
  logic [15:0]       slv_q, slv_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;

  logic        lfsr_load, lfsr_adv;
  logic [31:0] lfsr_value, lfsr_next;

  apb_bist_lfsr u_lfsr (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .load_i    (lfsr_load),
    .seed_i    (32'(seed[SeedW-1:0])),
    .advance_i (lfsr_adv),
    .value_o   (lfsr_value),
    .next_o    (lfsr_next)
  );

  // Decode of the transfer currently on the bus; every input is held stable from SETUP
  // through the end of ACCESS, so the APB outputs stay stable while waiting.
  logic              cur_write;
  logic [29:0]       cur_word;
  logic [DATA_W-1:0] cur_wdata;
  logic [StrbW-1:0]  cur_strb;
  logic [DATA_W-1:0] cur_exp;
  logic              cur_aor;
  logic [ADDR_W-1:0] cur_addr;
  int unsigned       lane;

  always_comb begin
    cur_write = 1'b0;
    cur_word  = '0;
    cur_wdata = '0;
    cur_strb  = '1;
    cur_exp   = '0;
    cur_aor   = 1'b0;
    lane      = 32'(idx_q) % StrbW;
    case (mode_q)
      ModeSeq, ModeB2b: begin
        cur_write = (phase_q == 2'd0);
        cur_word  = 30'(idx_q);
        cur_wdata = seed_q + DATA_W'(idx_q);
        cur_exp   = seed_q + DATA_W'(idx_q);
      end
      ModeRand: begin
        cur_write = (phase_q == 2'd0);
        cur_word  = cur_write ? 30'(lfsr_value[15:0] & WordLast) : 30'(rand_idx_q);
        cur_wdata = DATA_W'(lfsr_next);
        // The LFSR has already stepped to the written value by the time the read runs.
        cur_exp   = DATA_W'(lfsr_value);
      end
      ModeStrobe: begin
        cur_word = 30'(idx_q);
        if (phase_q == 2'd0) begin
          cur_write = 1'b1;
        end else if (phase_q == 2'd1) begin
          cur_write = 1'b1;
          cur_wdata = '1;
          cur_strb  = StrbW'(1) << lane;
        end
        for (int unsigned b = 0; b < StrbW; b++) begin
          cur_exp[8*b +: 8] = (b == lane) ? 8'hFF : 8'h00;
        end
      end
      ModeAor: begin
        cur_word = 30'(NUM_WORDS) + 30'(idx_q);
        cur_aor  = 1'b1;
      end
      default: ;
    endcase
    cur_addr = BASE_ADDR + ADDR_W'({cur_word, 2'b00});
  end

  // Position of the following transfer, and whether the current one ends the run.
  logic [15:0] eff_num, cnt_last, nxt_idx;
  logic [1:0]  nxt_phase;
  logic        is_last;

  always_comb begin
    eff_num   = (num_q == 16'd0) ? 16'd1 : num_q;
    cnt_last  = eff_num - 16'd1;
    nxt_idx   = idx_q;
    nxt_phase = phase_q;
    is_last   = 1'b0;
    case (mode_q)
      ModeSeq, ModeB2b: begin
        if (idx_q != WordLast) begin
          nxt_idx = idx_q + 16'd1;
        end else if (phase_q == 2'd0) begin
          nxt_idx   = '0;
          nxt_phase = 2'd1;
        end else begin
          is_last = 1'b1;
        end
      end
      ModeRand: begin
        if (phase_q == 2'd0) begin
          nxt_phase = 2'd1;
        end else if (idx_q == cnt_last) begin
          is_last = 1'b1;
        end else begin
          nxt_idx   = idx_q + 16'd1;
          nxt_phase = 2'd0;
        end
      end
      ModeStrobe: begin
        if (phase_q != 2'd2) begin
          nxt_phase = phase_q + 2'd1;
        end else if (idx_q == WordLast) begin
          is_last = 1'b1;
        end else begin
          nxt_idx   = idx_q + 16'd1;
          nxt_phase = 2'd0;
        end
      end
      ModeAor: begin
        if (idx_q == cnt_last) begin
          is_last = 1'b1;
        end else begin
          nxt_idx = idx_q + 16'd1;
        end
      end
      default: is_last = 1'b1;
    endcase
  end

  // Response classification. Out-of-range reads must error; data is only checked on a
  // read that completed without PSLVERR.
  logic rsp_err, rsp_slv;

  always_comb begin
    rsp_err = 1'b0;
    rsp_slv = 1'b0;
    if (cur_aor) begin
      rsp_slv = PSLVERR;
      rsp_err = !PSLVERR;
    end else if (PSLVERR) begin
      rsp_slv = 1'b1;
    end else if (!cur_write && (PRDATA != cur_exp)) begin
      rsp_err = 1'b1;
    end
  end

  logic mode_legal, pass_now;
  assign mode_legal = (mode_q <= ModeAor);
  assign pass_now   = mode_legal && (err_q == 16'd0) && !timeout_q &&
                      ((mode_q == ModeAor) ? (slv_q == eff_num) : (slv_q == 16'd0));

`ifdef APB_BIST_ERRLOG_EN
  logic              fvalid_q, fvalid_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fexp_q, fexp_d;
  logic [DATA_W-1:0] fact_q, fact_d;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    num_d      = num_q;
    seed_d     = seed_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    rand_idx_d = rand_idx_q;
    wait_d     = wait_q;
    last_d     = last_q;
    err_d      = err_q;
    slv_d      = slv_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
`ifdef APB_BIST_ERRLOG_EN
    fvalid_d   = fvalid_q;
    faddr_d    = faddr_q;
    fexp_d     = fexp_q;
    fact_d     = fact_q;
`endif
    case (state_q)
      StateIdle: begin
        if (start) begin
          mode_d     = mode;
          num_d      = num_xfers;
          seed_d     = seed;
          idx_d      = '0;
          phase_d    = '0;
          rand_idx_d = '0;
          last_d     = 1'b0;
          err_d      = '0;
          slv_d      = '0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
          lfsr_load  = 1'b1;
`ifdef APB_BIST_ERRLOG_EN
          fvalid_d   = 1'b0;
          faddr_d    = '0;
          fexp_d     = '0;
          fact_d     = '0;
`endif
          state_d    = (mode > ModeAor) ? StateFinish : StateSetup;
        end
      end
      StateSetup: begin
        wait_d  = '0;
        state_d = StateAccess;
      end
      StateAccess: begin
        if (PREADY) begin
          if (rsp_err) begin
            err_d = sat_inc16(err_q);
          end
          if (rsp_slv) begin
            slv_d = sat_inc16(slv_q);
          end
`ifdef APB_BIST_ERRLOG_EN
          if (rsp_err && !fvalid_q) begin
            fvalid_d = 1'b1;
            faddr_d  = cur_addr;
            fexp_d   = cur_exp;
            fact_d   = PRDATA;
          end
`endif
          if ((mode_q == ModeRand) && cur_write) begin
            lfsr_adv   = 1'b1;
            rand_idx_d = 16'(cur_word);
          end
          idx_d   = nxt_idx;
          phase_d = nxt_phase;
          if (mode_q == ModeB2b) begin
            state_d = is_last ? StateFinish : StateSetup;
          end else begin
            last_d  = is_last;
            state_d = StateNext;
          end
        end else if (wait_q == WaitW'(MAX_WAIT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StateFinish;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StateNext: begin
        state_d = last_q ? StateFinish : StateSetup;
      end
      StateFinish: begin
        pass_d  = pass_now;
        state_d = StateIdle;
      end
      default: state_d = StateIdle;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= StateIdle;
      mode_q     <= '0;
      num_q      <= '0;
      seed_q     <= '0;
      idx_q      <= '0;
      phase_q    <= '0;
      rand_idx_q <= '0;
      wait_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= '0;
      slv_q      <= '0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      seed_q     <= seed_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      rand_idx_q <= rand_idx_d;
      wait_q     <= wait_d;
      last_q     <= last_d;
      err_q      <= err_d;
      slv_q      <= slv_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
    end
  end

`ifdef APB_BIST_ERRLOG_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      fvalid_q <= 1'b0;
      faddr_q  <= '0;
      fexp_q   <= '0;
      fact_q   <= '0;
    end else begin
      fvalid_q <= fvalid_d;
      faddr_q  <= faddr_d;
      fexp_q   <= fexp_d;
      fact_q   <= fact_d;
    end
  end

  assign fail_valid = fvalid_q;
  assign fail_addr  = faddr_q;
  assign fail_exp   = fexp_q;
  assign fail_act   = fact_q;
`endif

  // Bus outputs are gated to zero outside a transfer so the idle bus is quiet.
  assign PSEL         = (state_q == StateSetup) || (state_q == StateAccess);
  assign PENABLE      = (state_q == StateAccess);
  assign PWRITE       = PSEL && cur_write;
  assign PADDR        = PSEL ? cur_addr : '0;
  assign PWDATA       = (PSEL && cur_write) ? cur_wdata : '0;
  assign PSTRB        = (PSEL && cur_write) ? cur_strb : '0;
  assign busy         = (state_q != StateIdle);
  assign done         = (state_q == StateFinish);
  assign pass         = done ? pass_now : pass_q;
  assign err_count    = err_q;
  assign slverr_count = slv_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_apb_bist_master.sv
// tb_apb_bist_master: scoreboard bench for apb_bist_master with a 16-word APB memory slave.
// Expected bus transfers are queued when a run is started and popped as the DUT completes
// them. Build with APB_BIST_ERRLOG_EN to also check the first-failure capture ports.
module tb_apb_bist_master;

  localparam int unsigned NW = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        start;
  logic [2:0]  mode;
  logic [15:0] num_xfers;
  logic [31:0] seed;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count, slverr_count;
`ifdef APB_BIST_ERRLOG_EN
  logic        fail_valid;
  logic [31:0] fail_addr, fail_exp, fail_act;
`endif

  always #5 PCLK = ~PCLK;

  apb_bist_master #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .BASE_ADDR (32'h0),
    .NUM_WORDS (NW),
    .MAX_WAIT  (16)
  ) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .start        (start),
    .mode         (mode),
    .num_xfers    (num_xfers),
    .seed         (seed),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PSTRB        (PSTRB),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .slverr_count (slverr_count),
    .timeout      (timeout)
`ifdef APB_BIST_ERRLOG_EN
    ,
    .fail_valid   (fail_valid),
    .fail_addr    (fail_addr),
    .fail_exp     (fail_exp),
    .fail_act     (fail_act)
`endif
  );

  // Memory slave: zero-wait, errors above the window, optional stuck PREADY and bit-0
  // corruption on reads of word 3.
  logic [31:0] mem [NW];
  logic        stuck, corrupt;
  logic        in_win;

  assign in_win  = (PADDR < 32'(4 * NW));
  assign PREADY  = !stuck;
  assign PSLVERR = PSEL && PENABLE && !in_win;

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && in_win) begin
      PRDATA = mem[PADDR[5:2]];
      if (corrupt && (PADDR[5:2] == 4'd3)) begin
        PRDATA[0] = ~PRDATA[0];
      end
    end
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE && in_win) begin
      for (int b = 0; b < 4; b++) begin
        if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        chk;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       mon_it;
  logic        mon_en;
  int unsigned acc_cyc, idle_cyc;

  always @(negedge PCLK) begin
    if (mon_en && PSEL && PENABLE && PREADY) begin
      check_eq("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_it = exp_q.pop_front();
        check_eq("pwrite", 64'(PWRITE), 64'(mon_it.wr));
        check_eq("paddr", 64'(PADDR), 64'(mon_it.addr));
        if (mon_it.wr) begin
          check_eq("pwdata", 64'(PWDATA), 64'(mon_it.data));
          check_eq("pstrb", 64'(PSTRB), 64'(mon_it.strb));
        end else begin
          check_eq("pstrb_rd", 64'(PSTRB), 64'd0);
          if (mon_it.chk) check_eq("prdata", 64'(PRDATA), 64'(mon_it.data));
        end
      end
    end
    if (PSEL && PENABLE) acc_cyc++;
    if (busy && !PSEL) idle_cyc++;
  end

  function automatic void push(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic chk);
    xfer_t it;
    it.wr   = wr;
    it.addr = addr;
    it.data = data;
    it.strb = strb;
    it.chk  = chk;
    exp_q.push_back(it);
  endfunction

  function automatic void push_seq(input logic [31:0] s, input int bad_word);
    for (int i = 0; i < NW; i++) push(1'b1, 32'(4 * i), s + 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < NW; i++) push(1'b0, 32'(4 * i), s + 32'(i), 4'h0, 1'(i != bad_word));
  endfunction

  function automatic void push_strobe();
    for (int i = 0; i < NW; i++) begin
      push(1'b1, 32'(4 * i), 32'h0, 4'hF, 1'b0);
      push(1'b1, 32'(4 * i), 32'hFFFF_FFFF, 4'(1 << (i % 4)), 1'b0);
      push(1'b0, 32'(4 * i), 32'hFF << (8 * (i % 4)), 4'h0, 1'b1);
    end
  endfunction

  function automatic void push_aor(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 32'(4 * NW + 4 * k), 32'h0, 4'h0, 1'b0);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic void push_rand(input logic [31:0] s, input int n);
    logic [31:0] v, nv;
    v = (s == 0) ? 32'd1 : s;
    for (int k = 0; k < n; k++) begin
      nv = lfsr_step(v);
      push(1'b1, {26'd0, v[3:0], 2'b00}, nv, 4'hF, 1'b0);
      push(1'b0, {26'd0, v[3:0], 2'b00}, nv, 4'h0, 1'b1);
      v = nv;
    end
  endfunction

  // Start a run and wait (bounded) for done; returns at the negedge where done is high,
  // plus #1 so the monitor has finished that edge. Optionally pulses start mid-run.
  task automatic run(input logic [2:0] m, input logic [15:0] n, input logic [31:0] s,
                     input bit poke);
    bit got;
    acc_cyc  = 0;
    idle_cyc = 0;
    @(negedge PCLK);
    mode = m; num_xfers = n; seed = s; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    got   = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = poke && (c == 10);
      mode  = (poke && (c == 10)) ? 3'd4 : m;
      @(negedge PCLK);
    end
    start = 1'b0;
    check_eq("done_seen", 64'(got), 64'd1);
    #1;
  endtask

  task automatic check_status(input string tag, input logic p, input logic [15:0] e,
                              input logic [15:0] sl, input logic t);
    check_eq({tag, "_pass"}, 64'(pass), 64'(p));
    check_eq({tag, "_err"}, 64'(err_count), 64'(e));
    check_eq({tag, "_slverr"}, 64'(slverr_count), 64'(sl));
    check_eq({tag, "_timeout"}, 64'(timeout), 64'(t));
    check_eq({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1; start = 1'b0; mode = '0; num_xfers = '0; seed = '0;
    stuck = 1'b0; corrupt = 1'b0; mon_en = 1'b1;
    repeat (3) @(negedge PCLK);
    check_eq("rst_psel", 64'(PSEL), 64'd0);
    check_eq("rst_penable", 64'(PENABLE), 64'd0);
    check_eq("rst_paddr", 64'(PADDR), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_pass", 64'(pass), 64'd0);
    check_eq("rst_cnts", 64'({err_count, slverr_count, 15'd0, timeout}), 64'd0);
    PRESET = 1'b0;

    // SEQ with a start pulse mid-run that must be ignored.
    push_seq(32'h1000, -1);
    run(3'd0, 16'd0, 32'h1000, 1'b1);
    check_status("seq", 1'b1, 16'd0, 16'd0, 1'b0);
    check_eq("seq_idle_cycles", 64'(idle_cyc), 64'd33);
    @(negedge PCLK);
    check_eq("seq_pass_held", 64'(pass), 64'd1);
    check_eq("seq_busy_after", 64'(busy), 64'd0);

    push_strobe();
    run(3'd2, 16'd0, 32'h0, 1'b0);
    check_status("strobe", 1'b1, 16'd0, 16'd0, 1'b0);

    push_aor(4);
    run(3'd4, 16'd4, 32'h0, 1'b0);
    check_status("aor4", 1'b1, 16'd0, 16'd4, 1'b0);

    push_aor(1);
    run(3'd4, 16'd0, 32'h0, 1'b0);
    check_status("aor0", 1'b1, 16'd0, 16'd1, 1'b0);

    push_rand(32'hACE1, 3);
    run(3'd1, 16'd3, 32'hACE1, 1'b0);
    check_status("rand", 1'b1, 16'd0, 16'd0, 1'b0);

    corrupt = 1'b1;
    push_seq(32'h2000, 3);
    run(3'd3, 16'd0, 32'h2000, 1'b0);
    check_status("b2b", 1'b0, 16'd1, 16'd0, 1'b0);
    check_eq("b2b_idle_cycles", 64'(idle_cyc), 64'd1);
`ifdef APB_BIST_ERRLOG_EN
    check_eq("errlog_valid", 64'(fail_valid), 64'd1);
    check_eq("errlog_addr", 64'(fail_addr), 64'hC);
    check_eq("errlog_exp", 64'(fail_exp), 64'h2003);
    check_eq("errlog_act", 64'(fail_act), 64'h2002);
`endif
    corrupt = 1'b0;

    stuck = 1'b1;
    run(3'd0, 16'd0, 32'h3000, 1'b0);
    check_eq("to_access_cycles", 64'(acc_cyc), 64'd16);
    check_eq("to_psel", 64'(PSEL), 64'd0);
    check_status("to", 1'b0, 16'd0, 16'd0, 1'b1);
    stuck = 1'b0;

    run(3'd5, 16'd0, 32'h0, 1'b0);
    check_status("illegal", 1'b0, 16'd0, 16'd0, 1'b0);
    check_eq("illegal_access", 64'(acc_cyc), 64'd0);

    // Reset in the middle of a long RAND run, then a clean run afterwards.
    mon_en = 1'b0;
    @(negedge PCLK);
    mode = 3'd1; num_xfers = 16'd100; seed = 32'h5; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    for (int c = 0; c < 50 && !(PSEL && PENABLE); c++) @(negedge PCLK);
    check_eq("mid_in_access", 64'(PSEL && PENABLE), 64'd1);
    repeat (4) @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    check_eq("mid_rst_bus", 64'({PSEL, PENABLE, PWRITE}), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_cnts", 64'({err_count, slverr_count, 15'd0, timeout}), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    mon_en = 1'b1;
    push_rand(32'h0, 4);
    run(3'd1, 16'd4, 32'h0, 1'b0);
    check_status("rand_after_rst", 1'b1, 16'd0, 16'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
